reg_file_param: RTL and testbench



---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_clear_seq.sv | 56 +++++
 rtl/reg_file_param.sv | 86 ++++++++
 tb/tb_reg_file_param.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the parametrised RV32I register file.
// Holds the clear/run state enum, default geometry and the hardwired-zero index.
package regfile_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_DEPTH = 32;
   localparam int ZERO_REG  = 0;

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: sweeps every entry to zero, one per cycle,
// then raises READY and stays in RUN until the next reset.
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          CLK,
   input  logic          RST,
   output logic          clr_we,
   output logic [AW-1:0] clr_addr,
   output logic          READY
);

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   state_t        state_reg, state_next;
   logic [AW-1:0] ptr_reg, ptr_next;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg <= CLEAR;
         ptr_reg   <= '0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      clr_we     = 1'b0;
      READY      = 1'b0;
      case (state_reg)
         CLEAR: begin
            clr_we   = 1'b1;
            ptr_next = ptr_reg + AW'(1);
            // The last entry is written on the same edge that enters RUN.
            if (ptr_reg == LAST) begin
               state_next = RUN;
            end
         end
         RUN: begin
            READY = 1'b1;
         end
         default: begin
            state_next = CLEAR;
         end
      endcase
   end

   assign clr_addr = ptr_reg;

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file: one write port, two registered read ports, x0 = 0.
// Optional write-to-read forwarding is enabled with `define REGFILE_BYPASS_EN.
module reg_file_param
   import regfile_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             W_EN,
   input  logic [AW-1:0]    address,
   input  logic [WIDTH-1:0] INIT,
   input  logic [AW-1:0]    space1,
   input  logic [AW-1:0]    space2,
   output logic [WIDTH-1:0] REG1,
   output logic [WIDTH-1:0] REG2,
   output logic             READY
);

   localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
   localparam logic [AW-1:0] X0      = AW'(ZERO_REG);

   // No reset on the array: the clear sequencer zeroes it after every reset.
   logic [WIDTH-1:0] mem [DEPTH];

   logic          clr_we;
   logic [AW-1:0] clr_addr;
   logic          wr_valid;
   logic [1:0][AW-1:0] raddr;

   regfile_clear_seq #(.DEPTH(DEPTH)) u_clear_seq (
      .CLK      (CLK),
      .RST      (RST),
      .clr_we   (clr_we),
      .clr_addr (clr_addr),
      .READY    (READY)
   );

   assign wr_valid = READY && W_EN && (address != X0) && ({1'b0, address} < DEPTH_W);
   assign raddr    = {space2, space1};

   always_ff @(posedge CLK) begin
      if (clr_we) begin
         mem[clr_addr] <= '0;
      end else if (wr_valid) begin
         mem[address] <= INIT;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rd
         logic [WIDTH-1:0] rd_next;
         logic [WIDTH-1:0] rdata_reg;

         always_comb begin
            rd_next = '0;
            if ((raddr[gi] != X0) && ({1'b0, raddr[gi]} < DEPTH_W)) begin
               rd_next = mem[raddr[gi]];
            end
`ifdef REGFILE_BYPASS_EN
            // Forward the word being written so the reader sees it this cycle.
            if (wr_valid && (address == raddr[gi])) begin
               rd_next = INIT;
            end
`endif
         end

         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               rdata_reg <= '0;
            end else if (!READY) begin
               rdata_reg <= '0;
            end else begin
               rdata_reg <= rd_next;
            end
         end
      end
   endgenerate

   assign REG1 = g_rd[0].rdata_reg;
   assign REG2 = g_rd[1].rdata_reg;

endmodule

// File: tb/tb_reg_file_param.sv
// Directed self-checking bench for reg_file_param (DEPTH=32 main instance,
// DEPTH=20 instance for out-of-range addresses); reads checked via a scoreboard queue.
module tb_reg_file_param;

   logic        CLK;
   logic        RST;
   logic        W_EN;
   logic [4:0]  address;
   logic [31:0] INIT;
   logic [4:0]  space1;
   logic [4:0]  space2;
   logic [31:0] REG1;
   logic [31:0] REG2;
   logic        READY;

   logic        w_en20;
   logic [4:0]  address20;
   logic [31:0] init20;
   logic [4:0]  s1_20;
   logic [4:0]  s2_20;
   logic [31:0] reg1_20;
   logic [31:0] reg2_20;
   logic        ready20;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_q [$];
   string       tag_q [$];

`ifdef REGFILE_BYPASS_EN
   localparam logic [31:0] COLL_EXP = 32'h0000_0009;
`else
   localparam logic [31:0] COLL_EXP = 32'h0000_0304;
`endif

   reg_file_param #(.WIDTH(32), .DEPTH(32)) u_dut (
      .CLK     (CLK),
      .RST     (RST),
      .W_EN    (W_EN),
      .address (address),
      .INIT    (INIT),
      .space1  (space1),
      .space2  (space2),
      .REG1    (REG1),
      .REG2    (REG2),
      .READY   (READY)
   );

   reg_file_param #(.WIDTH(32), .DEPTH(20)) u_dut20 (
      .CLK     (CLK),
      .RST     (RST),
      .W_EN    (w_en20),
      .address (address20),
      .INIT    (init20),
      .space1  (s1_20),
      .space2  (s2_20),
      .REG1    (reg1_20),
      .REG2    (reg2_20),
      .READY   (ready20)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive an optional write plus two read addresses, then check both outputs one edge later.
   task automatic rdw(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] a1, input logic [4:0] a2,
                      input logic [31:0] e1, input logic [31:0] e2, input string tag);
      logic [31:0] x1, x2;
      string t;
      @(negedge CLK);
      W_EN = we; address = wa; INIT = wd;
      space1 = a1; space2 = a2;
      exp_q.push_back(e1); exp_q.push_back(e2); tag_q.push_back(tag);
      @(posedge CLK);
      #1;
      W_EN = 1'b0;
      x1 = exp_q.pop_front(); x2 = exp_q.pop_front(); t = tag_q.pop_front();
      chk({t, "_reg1"}, REG1, x1);
      chk({t, "_reg2"}, REG2, x2);
   endtask

   task automatic rd(input logic [4:0] a1, input logic [4:0] a2,
                     input logic [31:0] e1, input logic [31:0] e2, input string tag);
      rdw(1'b0, 5'd0, 32'h0, a1, a2, e1, e2, tag);
   endtask

   task automatic wr(input logic [4:0] wa, input logic [31:0] wd);
      @(negedge CLK);
      W_EN = 1'b1; address = wa; INIT = wd;
      @(posedge CLK);
      #1;
      W_EN = 1'b0;
   endtask

   task automatic rd20(input logic [4:0] a1, input logic [31:0] e1, input string tag);
      @(negedge CLK);
      s1_20 = a1; s2_20 = a1;
      exp_q.push_back(e1); tag_q.push_back(tag);
      @(posedge CLK);
      #1;
      begin
         logic [31:0] x;
         string t;
         x = exp_q.pop_front(); t = tag_q.pop_front();
         chk({t, "_reg1"}, reg1_20, x);
         chk({t, "_reg2"}, reg2_20, x);
      end
   endtask

   initial begin
      RST = 1'b1; W_EN = 1'b0; address = '0; INIT = '0; space1 = '0; space2 = '0;
      w_en20 = 1'b0; address20 = '0; init20 = '0; s1_20 = '0; s2_20 = '0;

      repeat (3) @(posedge CLK);
      #1;
      chk("rst_ready", {31'd0, READY}, 32'd0);
      chk("rst_reg1", REG1, 32'd0);
      chk("rst_reg2", REG2, 32'd0);

      // Clear sweep; a write attempted at the second edge must be ignored.
      @(negedge CLK);
      RST = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (i != 0) @(negedge CLK);
         W_EN = (i == 1); address = 5'd3; INIT = 32'h0000_ABCD;
         @(posedge CLK);
         #1;
         chk($sformatf("sweep_ready_e%0d", i + 1), {31'd0, READY}, {31'd0, (i == 31)});
         chk($sformatf("sweep20_ready_e%0d", i + 1), {31'd0, ready20}, {31'd0, (i >= 19)});
         if (i < 31) chk($sformatf("sweep_reg1_e%0d", i + 1), REG1, 32'd0);
      end
      W_EN = 1'b0;

      for (int a = 1; a < 32; a++) begin
         rd(5'(a), 5'(a), 32'd0, 32'd0, $sformatf("cleared_a%0d", a));
      end

      wr(5'd5, 32'h0000_005C);
      rd(5'd5, 5'd0, 32'h0000_005C, 32'd0, "basic_rw");

      wr(5'd0, 32'hFFFF_FFFF);
      rd(5'd0, 5'd0, 32'd0, 32'd0, "x0_write");

      wr(5'd31, 32'hCAFE_F00D);
      rd(5'd31, 5'd5, 32'hCAFE_F00D, 32'h0000_005C, "top_entry");

      wr(5'd7, 32'h0000_0304);
      rdw(1'b1, 5'd7, 32'h0000_0009, 5'd7, 5'd7, COLL_EXP, COLL_EXP, "collision");
      rd(5'd7, 5'd7, 32'h0000_0009, 32'h0000_0009, "after_collision");
      rd(5'd3, 5'd3, 32'd0, 32'd0, "clear_write_dropped");

      // DEPTH=20 instance: address 25 is out of range, 19 is the last valid entry.
      @(negedge CLK);
      w_en20 = 1'b1; address20 = 5'd25; init20 = 32'hDEAD_BEEF;
      @(negedge CLK);
      address20 = 5'd19; init20 = 32'h0000_0019;
      @(negedge CLK);
      w_en20 = 1'b0;
      rd20(5'd25, 32'd0, "oor_25");
      rd20(5'd19, 32'h0000_0019, "last_19");

      // Reset mid-run: outputs drop asynchronously, sweep repeats.
      wr(5'd10, 32'h1234_5678);
      rd(5'd10, 5'd10, 32'h1234_5678, 32'h1234_5678, "pre_reset");
      @(negedge CLK);
      RST = 1'b1;
      #1;
      chk("midrst_ready", {31'd0, READY}, 32'd0);
      chk("midrst_reg1", REG1, 32'd0);
      chk("midrst_reg2", REG2, 32'd0);
      #1;
      RST = 1'b0;
      for (int i = 0; i < 32; i++) begin
         @(posedge CLK);
         #1;
         chk($sformatf("resweep_ready_e%0d", i + 1), {31'd0, READY}, {31'd0, (i == 31)});
      end
      rd(5'd10, 5'd10, 32'd0, 32'd0, "post_reset_a10");
      rd(5'd5, 5'd31, 32'd0, 32'd0, "post_reset_a5_a31");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
